// File: rtl/wb_shared_bus_arbiter.sv
// Shared-bus Wishbone B4 classic interconnect: two masters, round-robin
// ownership, owner address decode, unmapped and timeout error generation.
module wb_shared_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [1:0]                              m_cyc,
    input  logic [1:0]                              m_stb,
    input  logic [1:0]                              m_we,
    input  logic [1:0][DATA_WIDTH/8-1:0]            m_sel,
    input  logic [1:0][ADDR_WIDTH-1:0]              m_adr,
    input  logic [1:0][DATA_WIDTH-1:0]              m_dat_w,
    output logic [DATA_WIDTH-1:0]                   m_dat_r,
    output logic [1:0]                              m_ack,
    output logic [1:0]                              m_err,
    output logic [NUM_SLAVES-1:0]                   s_cyc,
    output logic [NUM_SLAVES-1:0]                   s_stb,
    output logic                                    s_we,
    output logic [DATA_WIDTH/8-1:0]                 s_sel,
    output logic [ADDR_WIDTH-1:0]                   s_adr,
    output logic [DATA_WIDTH-1:0]                   s_dat_w,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   s_dat_r,
    input  logic [NUM_SLAVES-1:0]                   s_ack,
    input  logic [NUM_SLAVES-1:0]                   s_err
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, OWN0, OWN1, ERR0, ERR1} state_t;

    state_t        state;
    logic          last_owner;
    logic          tmo_err;
    logic [15:0]   tmo_cnt;

    logic          owner;
    logic          owned;
    logic          in_err;
    logic          held;
    logic          req;
    logic          hit_any;
    logic [IW-1:0] hit_idx;
    logic          sel_ack;
    logic          sel_err;
    logic          resp_ack;
    logic          resp_err;

    assign owner  = (state == OWN1) || (state == ERR1);
    assign owned  = (state == OWN0) || (state == OWN1);
    assign in_err = (state == ERR0) || (state == ERR1);
    assign held   = owned | in_err;

    assign s_we    = held & m_we[owner];
    assign s_sel   = held ? m_sel[owner]   : '0;
    assign s_adr   = held ? m_adr[owner]   : '0;
    assign s_dat_w = held ? m_dat_w[owner] : '0;

    assign req = owned & m_cyc[owner] & m_stb[owner];

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((s_adr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        s_cyc = '0;
        s_stb = '0;
        if (owned && m_cyc[owner] && hit_any) begin
            s_cyc[hit_idx] = 1'b1;
            s_stb[hit_idx] = m_stb[owner] & ~tmo_err;
        end
    end

    assign sel_ack  = s_stb[hit_idx] & s_ack[hit_idx];
    assign sel_err  = s_stb[hit_idx] & s_err[hit_idx];
    assign resp_err = sel_err | (owned & tmo_err) | in_err;
    assign resp_ack = sel_ack & ~sel_err;
    assign m_dat_r  = (|s_stb) ? s_dat_r[hit_idx] : '0;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (held) begin
            m_ack[owner] = resp_ack;
            m_err[owner] = resp_err;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            tmo_err    <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            tmo_err <= 1'b0;
            tmo_cnt <= '0;
            if (req && hit_any && !tmo_err && !sel_ack && !sel_err) begin
                if (tmo_cnt == TMO_LAST) tmo_err <= 1'b1;
                else                     tmo_cnt <= tmo_cnt + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (m_cyc[0] && (!m_cyc[1] || last_owner)) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                    end else if (m_cyc[1]) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!m_cyc[owner])         state <= IDLE;
                    else if (req && !hit_any)  state <= owner ? ERR1 : ERR0;
                end
                ERR0:    state <= m_cyc[0] ? OWN0 : IDLE;
                ERR1:    state <= m_cyc[1] ? OWN1 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// Directed scenarios plus randomized two-master traffic checked by a
// response scoreboard against an address-map reference model.
module tb_wb_shared_bus_arbiter;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } mdrv_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h1000_0000,
                                         32'h2000_0000, 32'h3000_0000};
    localparam logic [31:0] MASK [4] = '{32'hFFFF_0000, 32'hFFF0_0000,
                                         32'hFFFF_FFF0, 32'hFFFF_FFE0};

    logic              clock = 1'b0;
    logic              reset;
    mdrv_t             md0, md1;
    logic [1:0]        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [1:0][3:0]   m_sel;
    logic [1:0][31:0]  m_adr, m_dat_w;
    logic [31:0]       m_dat_r;
    logic [3:0]        s_cyc, s_stb, s_ack, s_err, s_sel;
    logic              s_we;
    logic [31:0]       s_adr, s_dat_w;
    logic [3:0][31:0]  s_dat_r;

    logic [3:0]  wcnt [4];
    logic [7:0]  noise;
    logic        noise_en = 1'b0;
    logic        mon_en = 1'b0;
    exp_t        q0[$], q1[$];
    int          vectors = 0;
    int          miscompares = 0;

    assign m_cyc   = {md1.cyc, md0.cyc};
    assign m_stb   = {md1.stb, md0.stb};
    assign m_we    = {md1.we, md0.we};
    assign m_sel   = {md1.sel, md0.sel};
    assign m_adr   = {md1.adr, md0.adr};
    assign m_dat_w = {md1.dat, md0.dat};

    always #5 clock = ~clock;

    wb_shared_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err)
    );

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    // Slave behaviour keyed by address: 0 ack, 1 ack after 2 waits,
    // 2 err, 3 ack+err together, 4 (ram with bit 19) never answers.
    function automatic int smode(input int i, input logic [31:0] a);
        if (i == 1 && a[19]) return 4;
        return int'(a[3:2]);
    endfunction

    function automatic logic [31:0] sdata(input int i, input logic [31:0] a);
        return a ^ {8'(i + 1), 24'hC35A96};
    endfunction

    function automatic exp_t ref_expect(input logic [31:0] a);
        exp_t e;
        int   idx;
        idx = ref_decode(a);
        e.err  = (idx < 0) || (smode(idx, a) >= 2);
        e.data = e.err ? 32'h0 : sdata(idx, a);
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1: a = {16'h0, 16'($urandom)};
            2, 3: begin
                a = 32'h1000_0000 | (32'($urandom) & 32'h0007_FFFC);
                if ($urandom_range(0, 9) == 0) a[19] = 1'b1;
            end
            4, 5: a = 32'h2000_0000 | (32'($urandom) & 32'hF);
            6, 7: a = 32'h3000_0000 | (32'($urandom) & 32'h1F);
            8:    a = 32'h4000_0000 | (32'($urandom) & 32'h0FFF_FFFF);
            default: case ($urandom_range(0, 3))
                0:       a = 32'h2000_0010 | (32'($urandom) & 32'hFF);
                1:       a = 32'h3000_0020 | (32'($urandom) & 32'hFF);
                2:       a = 32'h0001_0000 | (32'($urandom) & 32'hFFF);
                default: a = 32'h1010_0000 | (32'($urandom) & 32'hFFF);
            endcase
        endcase
        return a;
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            wcnt[i] <= s_stb[i] ? wcnt[i] + 4'd1 : 4'd0;
        noise <= noise_en ? 8'($urandom & $urandom) : 8'h0;
    end

    always_comb begin
        s_ack = '0;
        s_err = '0;
        for (int i = 0; i < 4; i++) begin
            s_dat_r[i] = sdata(i, s_adr);
            if (s_stb[i]) begin
                case (smode(i, s_adr))
                    0: s_ack[i] = 1'b1;
                    1: s_ack[i] = (wcnt[i] >= 4'd2);
                    2: s_err[i] = 1'b1;
                    3: begin s_ack[i] = 1'b1; s_err[i] = 1'b1; end
                    default: ;
                endcase
            end else begin
                s_ack[i] = noise[i];
                s_err[i] = noise[i+4];
            end
        end
    end

    function automatic logic bus_is(input mdrv_t d);
        return d.cyc && s_adr == d.adr && s_we == d.we &&
               s_sel == d.sel && s_dat_w == d.dat;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        int   idx;
        if (mon_en) begin
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m] || m_err[m]) begin
                    vectors++;
                    if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                        miscompares++;
                        $display("FAIL resp m%0d: got ack=%0b err=%0b, expected no response",
                                 m, m_ack[m], m_err[m]);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        if (m_err[m] !== e.err || m_ack[m] !== !e.err ||
                            (!e.err && m_dat_r !== e.data)) begin
                            miscompares++;
                            $display("FAIL resp m%0d: got ack=%0b err=%0b data=%h, expected err=%0b data=%h",
                                     m, m_ack[m], m_err[m], m_dat_r, e.err, e.data);
                        end
                    end
                end
            end
            if (s_stb != 4'b0) begin
                vectors++;
                idx = ref_decode(s_adr);
                if (idx < 0 || s_stb != 4'(1 << idx) || !(bus_is(md0) || bus_is(md1))) begin
                    miscompares++;
                    $display("FAIL slave bus: got s_stb=%b adr=%h we=%0b, expected decode %0d of an active master",
                             s_stb, s_adr, s_we, idx);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic set_m(input int m, input logic c, input logic s, input logic w,
                         input logic [3:0] se, input logic [31:0] a, input logic [31:0] d);
        mdrv_t v;
        v.cyc = c; v.stb = s; v.we = w; v.sel = se; v.adr = a; v.dat = d;
        if (m == 0) md0 = v;
        else        md1 = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic drive_master(input int m, input int n);
        logic [31:0] a;
        int          to;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
            a = rand_addr();
            if (m == 0) q0.push_back(ref_expect(a));
            else        q1.push_back(ref_expect(a));
            set_m(m, 1'b1, 1'b1, 1'($urandom), 4'($urandom_range(1, 15)), a, $urandom);
            to = 0;
            do begin
                @(negedge clock);
                to++;
            end while (!(m_ack[m] || m_err[m]) && to < 300);
            if (!(m_ack[m] || m_err[m])) begin
                vectors++;
                miscompares++;
                $display("FAIL wait m%0d: got no response in 300 cycles, expected ack or err", m);
            end
            tick();
            set_m(m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b0;
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        chk("reset ctl", 64'({m_ack, m_err, s_cyc, s_stb, s_we, s_sel}), 64'h0);
        chk("reset bus", {s_adr, s_dat_w}, 64'h0);
        chk("reset dat", 64'(m_dat_r), 64'h0);
        reset = 1'b1;

        // basic read on bootRom
        tick();
        set_m(0, 1, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
        smp(); chk("t1 latency", 64'(s_stb), 64'h0);
        tick(); smp();
        chk("t1 s_stb", 64'(s_stb), 64'b0001);
        chk("t1 ack", 64'(m_ack), 64'b01);
        chk("t1 data", 64'(m_dat_r), 64'(sdata(0, 32'h10)));
        tick(); set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        smp(); chk("t1 release", 64'({m_ack, s_cyc}), 64'h0);
        tick();

        // simultaneous requests and round-robin
        do_reset();
        tick();
        set_m(0, 1, 1, 0, 4'hF, 32'h0000_0020, 32'h0);
        set_m(1, 1, 1, 0, 4'hF, 32'h3000_0000, 32'h0);
        smp(); chk("t2 idle", 64'(s_stb), 64'h0);
        tick(); smp();
        chk("t2 first grant", 64'({m_ack, s_stb}), 64'({2'b01, 4'b0001}));
        tick(); set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        smp(); chk("t2 release", 64'(s_stb), 64'h0);
        tick(); smp(); chk("t2 idle gap", 64'(s_stb), 64'h0);
        tick(); smp();
        chk("t2 second grant", 64'({m_ack, s_stb}), 64'({2'b10, 4'b1000}));
        chk("t2 data", 64'(m_dat_r), 64'(sdata(3, 32'h3000_0000)));
        tick(); set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // write to led with wait states
        set_m(1, 1, 1, 1, 4'b0001, 32'h2000_0004, 32'hA5);
        smp(); chk("t3 idle", 64'(s_stb), 64'h0);
        tick(); smp();
        chk("t3 s_stb", 64'(s_stb), 64'b0100);
        chk("t3 we sel dat", 64'({s_we, s_sel, s_dat_w}), 64'({1'b1, 4'b0001, 32'hA5}));
        chk("t3 wait0", 64'(m_ack), 64'h0);
        tick(); smp(); chk("t3 wait1", 64'(m_ack), 64'h0);
        tick(); smp(); chk("t3 ack", 64'(m_ack), 64'b10);
        tick(); set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // unmapped address
        set_m(0, 1, 1, 0, 4'hF, 32'h4000_0000, 32'h0);
        smp();
        tick(); smp();
        chk("t4 no stb", 64'({s_cyc, s_stb}), 64'h0);
        chk("t4 no early err", 64'(m_err), 64'h0);
        tick(); set_m(0, 1, 0, 0, 4'hF, 32'h4000_0000, 32'h0);
        smp(); chk("t4 err", 64'({m_err, m_ack}), 64'({2'b01, 2'b00}));
        tick(); smp(); chk("t4 single pulse", 64'(m_err), 64'h0);
        tick(); set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // timeout on silent ram, then ack+err priority
        set_m(1, 1, 1, 0, 4'hF, 32'h1008_0000, 32'h0);
        smp();
        tick();
        for (int k = 1; k <= 8; k++) begin
            smp();
            chk("t5 waiting", 64'({m_err, m_ack, s_stb}), 64'h02);
            tick();
        end
        smp();
        chk("t5 timeout err", 64'(m_err), 64'b10);
        chk("t5 stb dropped", 64'(s_stb), 64'h0);
        tick(); smp();
        chk("t5 single pulse", 64'({m_err, s_stb}), 64'({2'b00, 4'b0010}));
        tick(); set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick();
        set_m(0, 1, 1, 0, 4'hF, 32'h0000_000C, 32'h0);
        smp();
        tick(); smp();
        chk("t5 ack+err", 64'({m_err, m_ack}), 64'({2'b01, 2'b00}));
        tick(); set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // reset in the middle of a transfer
        set_m(0, 1, 1, 0, 4'hF, 32'h0000_0004, 32'h0);
        smp();
        tick(); smp(); chk("t6 owned", 64'(s_stb), 64'b0001);
        set_m(1, 1, 1, 1, 4'hF, 32'h3000_0004, 32'h1234);
        #1 reset = 1'b0;
        #1;
        chk("t6 reset ctl", 64'({m_ack, m_err, s_cyc, s_stb, s_we, s_sel}), 64'h0);
        chk("t6 reset bus", {s_adr, s_dat_w}, 64'h0);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        tick(); smp();
        chk("t6 grant", 64'(s_cyc), 64'b1000);
        chk("t6 silent", 64'({m_ack[0], m_err[0]}), 64'h0);
        tick(); set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // randomized traffic from both masters
        do_reset();
        noise_en = 1'b1;
        mon_en   = 1'b1;
        fork
            drive_master(0, 150);
            drive_master(1, 150);
        join
        repeat (5) tick();
        mon_en = 1'b0;
        chk("q0 drained", 64'(q0.size()), 64'h0);
        chk("q1 drained", 64'(q1.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
        $fatal(1);
    end

endmodule
